// File: rtl/universal_shift_reg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | universal_shift_reg_seq: universal shift register, command handshake,      |
// | multi-cycle shift sequencing (one bit per clock).   Rev 1.0                 |
// +----------------------------------------------------------------------------+
module universal_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_mode_hold  = 3'd0;
  localparam logic [2:0] c_mode_shr   = 3'd1;
  localparam logic [2:0] c_mode_shl   = 3'd2;
  localparam logic [2:0] c_mode_load  = 3'd3;
  localparam logic [2:0] c_mode_ror   = 3'd4;
  localparam logic [2:0] c_mode_rol   = 3'd5;
  localparam logic [2:0] c_mode_asr   = 3'd6;
  localparam logic [2:0] c_mode_clear = 3'd7;

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out,   w_out_nxt;
  logic [CNT_W-1:0] r_rem,   w_rem_nxt;
  logic [2:0]       r_mode,  w_mode_nxt;
  logic             r_done,  w_done_nxt;
  logic             w_accept;

  // Single one-bit step; non-shift modes pass the value through unchanged.
  function automatic logic [WIDTH-1:0] f_shift1(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] v,
    input logic             sr,
    input logic             sl
  );
    logic [WIDTH-1:0] res;
    case (mode)
      c_mode_shr: res = {sr, v[WIDTH-1:1]};
      c_mode_shl: res = {v[WIDTH-2:0], sl};
      c_mode_ror: res = {v[0], v[WIDTH-1:1]};
      c_mode_rol: res = {v[WIDTH-2:0], v[WIDTH-1]};
      c_mode_asr: res = {v[WIDTH-1], v[WIDTH-1:1]};
      default:    res = v;
    endcase
    return res;
  endfunction

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_SHIFT);
  assign w_accept  = cmd_valid && cmd_ready;
  assign out       = r_out;
  assign ser_out_r = r_out[0];
  assign ser_out_l = r_out[WIDTH-1];
  assign done      = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_rem_nxt   = r_rem;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_mode_nxt = cmd_mode;
          case (cmd_mode)
            c_mode_hold: w_done_nxt = 1'b1;
            c_mode_load: begin
              w_out_nxt  = par_in;
              w_done_nxt = 1'b1;
            end
            c_mode_clear: begin
              w_out_nxt  = '0;
              w_done_nxt = 1'b1;
            end
            default: begin
              // First shift happens on the accept edge itself.
              if (cmd_count == c_cnt_zero) begin
                w_done_nxt = 1'b1;
              end else begin
                w_out_nxt = f_shift1(cmd_mode, r_out, ser_in_r, ser_in_l);
                w_rem_nxt = cmd_count - c_cnt_one;
                if (cmd_count == c_cnt_one) w_done_nxt  = 1'b1;
                else                        w_state_nxt = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        w_out_nxt = f_shift1(r_mode, r_out, ser_in_r, ser_in_l);
        w_rem_nxt = r_rem - c_cnt_one;
        if (r_rem == c_cnt_one) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_rem   <= '0;
      r_mode  <= c_mode_hold;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_rem   <= w_rem_nxt;
      r_mode  <= w_mode_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire
